// File: rtl/median_window_ctrl.sv
// Raster-scan front-end for a 3x3 median filter. It keeps two line buffers and a 3x3 window,
// and presents each window to the median datapath through a one-entry valid/ready stage.
module median_window_ctrl #(
   parameter  int DATA_W = 8,
   parameter  int IMG_W  = 400,
   parameter  int IMG_H  = 400,
   localparam int XW     = $clog2(IMG_W),
   localparam int YW     = $clog2(IMG_H)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_sof,
   input  logic [DATA_W-1:0]   in_data,
   output logic                win_valid,
   input  logic                win_ready,
   output logic [9*DATA_W-1:0] win_data,
   output logic [XW-1:0]       win_x,
   output logic [YW-1:0]       win_y,
   output logic                frame_done
);

   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
   localparam logic [XW-1:0] X_ONE  = XW'(1);
   localparam logic [YW-1:0] Y_ONE  = YW'(1);
   localparam logic [XW-1:0] X_TWO  = XW'(2);
   localparam logic [YW-1:0] Y_TWO  = YW'(2);

   logic [XW-1:0]          x_q, cur_x;
   logic [YW-1:0]          y_q, cur_y;
   logic                   acc, emit, last_col, last_row;
   logic [DATA_W-1:0]      lb0 [IMG_W];
   logic [DATA_W-1:0]      lb1 [IMG_W];
   logic [DATA_W-1:0]      lb0_rd, lb1_rd;
   logic [2:0][DATA_W-1:0] row0, row1, row2;

   // The skid stage frees up as soon as its window is taken, so in_ready never depends on in_valid.
   assign in_ready = !win_valid || win_ready;
   assign acc      = in_valid && in_ready;

   // A start-of-frame pixel is placed at (0,0) wherever the counters happened to be.
   assign cur_x    = in_sof ? '0 : x_q;
   assign cur_y    = in_sof ? '0 : y_q;
   assign last_col = (cur_x == X_LAST);
   assign last_row = (cur_y == Y_LAST);
   assign emit     = (cur_x >= X_TWO) && (cur_y >= Y_TWO);

   assign lb0_rd   = lb0[cur_x];
   assign lb1_rd   = lb1[cur_x];

   // NOTE: sequential state is written with non-blocking assignments so every register
   // samples pre-edge values, independent of the order of the blocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else if (acc) begin
         if (last_col) begin
            x_q <= '0;
            y_q <= last_row ? '0 : cur_y + Y_ONE;
         end else begin
            x_q <= cur_x + X_ONE;
            y_q <= cur_y;
         end
      end
   end

   // NOTE: the line buffers are plain RAM with no reset; stale contents never reach the
   // output because windows are only emitted once two full rows of this frame are stored.
   always_ff @(posedge clk) begin
      if (acc) begin
         lb0[cur_x] <= lb1_rd;
         lb1[cur_x] <= in_data;
      end
   end

   // Each row shifts toward index 0, so index 0 holds the oldest column (x-2).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row0 <= '0;
         row1 <= '0;
         row2 <= '0;
      end else if (acc) begin
         row0 <= {lb0_rd,  row0[2:1]};
         row1 <= {lb1_rd,  row1[2:1]};
         row2 <= {in_data, row2[2:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         win_x      <= '0;
         win_y      <= '0;
      end else if (acc && emit) begin
         win_valid  <= 1'b1;
         frame_done <= last_col && last_row;
         win_x      <= cur_x - X_ONE;
         win_y      <= cur_y - Y_ONE;
      end else if (win_valid && win_ready) begin
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end
   end

   // The window rows only shift on acc, which cannot happen while a window is stalled.
   assign win_data = {row2, row1, row0};

endmodule

// File: doc/median_window_ctrl.md
Name: median_window_ctrl

Overview:
- Streaming front-end that sequences the 3x3 combinational median filter over a raster-order image.
- Accepts one pixel per handshake from the pixel source.
- Keeps two line buffers and a 3x3 shift window, and presents the nine taps plus center coordinates to the median datapath with a valid/ready handshake.
- Produces (IMG_W-2)x(IMG_H-2) windows per frame, i.e. 398x398 for the 400x400 image, and pulses frame_done after the last one.

Parameters:
DATA_W, 8, pixel width in bits
IMG_W, 400, pixels per line (min 3)
IMG_H, 400, lines per frame (min 3)

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  pixel available
in_ready  out  1  controller can accept the pixel
in_sof  in  1  qualifies the accepted pixel as (0,0) of a new frame
in_data  in  DATA_W  pixel value
win_valid  out  1  window taps valid
win_ready  in  1  median consumer accepts the window
win_data  out  9*DATA_W  taps w0..w8, w0 in bits [DATA_W-1:0]
win_x  out  clog2(IMG_W)  center column of the window (x-1)
win_y  out  clog2(IMG_H)  center row of the window (y-1)
frame_done  out  1  one-cycle pulse on the final window of the frame

Behaviour:
- Accept: acc = in_valid && in_ready. in_ready = !win_valid || win_ready (one-entry output skid; no combinational path from in_valid to in_ready).
- Counters x, y: position of the pixel being accepted.
  - On acc: if x==IMG_W-1, x wraps to 0 and y increments; else x increments.
  - If additionally y==IMG_H-1, y wraps to 0.
  - On acc with in_sof=1: the pixel is treated as (0,0); counters then advance to (1,0), regardless of their prior value.
- Line buffers LB0 (row y-2) and LB1 (row y-1): IMG_W x DATA_W each, addressed by x.
  - On acc: read LB0[x] and LB1[x], then write LB0[x]<=LB1[x] and LB1[x]<=in_data.
  - Read-before-write at the same address.
- Window registers: three 3-deep shift rows.
  - On acc, row0 shifts in LB0[x], row1 shifts in LB1[x], row2 shifts in in_data.
  - Tap order: w0..w2 = row y-2, cols x-2..x; w3..w5 = row y-1; w6..w8 = row y (oldest column first).
  - For linear pixel index i = y*IMG_W + x, taps are img[i-2W-2], img[i-2W-1], img[i-2W], img[i-W-2] ... img[i], with W = IMG_W.
- Window emission:
  - On acc with x>=2 and y>=2 (evaluated with the pre-increment counters), the next cycle has win_valid=1.
  - In that cycle, win_data holds the taps including the new pixel, win_x=x-1, win_y=y-1. Latency is 1 cycle.
  - win_valid clears on win_valid && win_ready unless a new window is loaded in the same cycle.
  - win_data, win_x and win_y are held stable while win_valid && !win_ready.
- frame_done: asserted together with the window whose center is (IMG_W-2, IMG_H-2); held while that window stalls; deasserts with its handshake.
- Pixels with x<2 or y<2 update the buffers but emit no window.
- Reset (asynchronous, any time, including mid-frame):
  - x=0, y=0, win_valid=0, frame_done=0, win_data=0, win_x=0, win_y=0.
  - in_ready=1 after reset.
  - Line buffer contents are not reset; the x>=2/y>=2 gating keeps stale data from being emitted.
- Simultaneous handshake and load: an output handshake and a new acc in the same cycle keeps win_valid=1 and loads the new window with no bubble.
- Sustained throughput is 1 window per cycle when win_ready=1.

Test Plan:
1. First window, IMG_W=5, IMG_H=4, pixel=(y*5+x), win_ready=1, continuous valid.
   - First win_valid comes 1 cycle after pixel (2,2) is accepted.
   - Required: taps 0,1,2,5,6,7,10,11,12; win_x=1, win_y=1.
2. Full frame, same config.
   - Required: exactly 6 windows, centers (1,1),(2,1),(3,1),(1,2),(2,2),(3,2).
   - Last taps 7,8,9,12,13,14,17,18,19.
   - frame_done high only with the last window.
3. Backpressure: hold win_ready=0 for 3 cycles while win_valid=1.
   - Required: in_ready=0, and win_data/win_x/win_y unchanged for those cycles.
   - After release, no window is lost or duplicated; 6 windows total.
4. Back-to-back frames, with in_sof on the first pixel of frame 2.
   - Required: frame 2's first window again has center (1,1) with frame-2 data.
   - No window is emitted for x<2 or y<2 of frame 2.
5. Reset mid-frame: assert rst_n=0 after 8 pixels.
   - Required: win_valid=0 and frame_done=0 immediately (asynchronously).
   - A restarted frame produces exactly 6 correct windows.
6. Default 400x400 with img.txt data.
   - Required: 158404 windows.
   - First window taps are img[0,1,2,400,401,402,800,801,802], center (1,1).
   - frame_done is asserted with the window centered at (398,398).
